stream_demuxer_n: RTL and testbench
===================================

Name: stream_demuxer_n

Overview:
Parametrised 1-to-N demultiplexer for data streams, N = 2^S. Each input word is steered to one of N output channels. The target channel comes from the select input (addressed mode) or from an internal round-robin pointer (scan mode). Each output channel has a one-entry holding register with valid/ready handshake, so back-pressure on one channel does not corrupt the others. This is the registered, handshaked, width- and depth-generalised successor of the combinational 1-to-8 demultiplexer, for use wherever a producer feeds several consumers.

Parameters:
W, 8, data word width in bits (>=1)
S, 3, select width; channel count N = 2^S (S >= 1)

Ports:
clock  in  1  system clock, rising edge
reset_  in  1  asynchronous, active-low reset
mode  in  1  0 = addressed (use in_sel), 1 = round-robin (use rr_ptr)
in_data  in  W  input word
in_sel  in  S  target channel in addressed mode; ignored in round-robin mode
in_valid  in  1  producer offers in_data
in_ready  out  1  block accepts in_data this cycle
out_data  out  N*W  channel k occupies bits [k*W+W-1 : k*W]
out_valid  out  N  channel k holds a word
out_ready  in  N  consumer k takes its word this cycle
rr_ptr  out  S  current round-robin target (observability)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (reset_). All state updates on the rising edge of clock.
- Reset (reset_ = 0, at any time, including mid-transfer): out_valid = 0, out_data = 0, rr_ptr = 0. Any held or in-flight word is discarded. in_ready follows from the cleared state, so it reads 1.
- Target t = mode ? rr_ptr : in_sel; t is combinational.
- in_ready = ~out_valid[t] | out_ready[t]. This is combinational from mode, in_sel, rr_ptr, out_valid and out_ready. Consumers must not make out_ready depend on in_ready.
- Accept = in_valid & in_ready. On accept at edge k:
  - out_data[t] <= in_data
  - out_valid[t] <= 1, visible after edge k (latency 1 cycle)
- Drain: if out_valid[j] & out_ready[j] and channel j is not loaded in the same cycle, out_valid[j] <= 0. out_data[j] holds its last value.
- Simultaneous drain and load on the same channel: the new word replaces the old one, out_valid stays 1, and no bubble is inserted. This sustains full throughput of 1 word/cycle per channel.
- Channels other than t are affected only by their own out_ready.
- Round-robin pointer:
  - Advances only on accept while mode = 1: rr_ptr <= rr_ptr + 1 modulo N, so it wraps from N-1 to 0.
  - With mode = 1, if the target channel is full and not draining, in_ready = 0 and the pointer stalls. There is no skipping to a free channel.
  - With mode = 0, rr_ptr holds its value.
- Mode changes take effect in the same cycle; no flush. Words already held remain valid.
- in_valid = 0: no state change except drains. in_data and in_sel are don't-care.
- No data is ever lost or duplicated. Each accepted word appears exactly once, on exactly one channel.

Decomposition:
- Shared package/header: mode encoding constants (MODE_ADDR = 1'b0, MODE_RR = 1'b1).
- Sub-module demux_chan_buf (parameter W), instantiated N times via generate. It is the one-entry holding register with inputs clock, reset_, load, d, ready and outputs q, valid, and implements the load/drain/simultaneous rules above.
- Top level contains:
  - the target mux
  - the in_ready logic
  - the one-hot load decode (this replaces the old gate-level demux)
  - the rr_ptr counter

Test Plan:
1. Reset, then addressed mode, W=8, S=3, all out_ready = 0. Send 0xA5 to sel 5 → in_ready = 1; after 1 cycle out_valid = 8'b0010_0000 and channel 5 data = 0xA5. A second word to sel 5 → in_ready = 0 until out_ready[5] pulses.
2. Drain and load same cycle: channel 2 holds 0x11 and out_ready[2] = 1 while 0x22 is sent to sel 2 → in_ready = 1; next cycle out_valid[2] = 1 and data = 0x22. Continuous streaming achieves 1 word/cycle.
3. Round-robin, all out_ready = 1. Send 10 words 0..9 → channels receive 0,1,...,7,0,1 in order; rr_ptr ends at 2 (wrap from 7 to 0 observed).
4. Round-robin stall: out_ready[3] = 0 and channel 3 full with rr_ptr = 3 → in_ready = 0 and rr_ptr stays 3 for 5 cycles. Raising out_ready[3] → accept, then rr_ptr = 4.
5. Mode switch: in addressed mode send 3 words to sel 6 with rr_ptr = 4 → rr_ptr stays 4. Switch to mode 1 → the next word lands on channel 4.
6. Reset mid-operation: channels 0, 3 and 7 valid, assert reset_ low asynchronously between edges → out_valid = 0, out_data = 0, rr_ptr = 0 immediately, without waiting for a clock edge. After release, normal operation resumes.

Source files
------------

// File: rtl/stream_demuxer_n_pkg.sv
// Shared constants for the stream demultiplexer: mode encodings and defaults.
package stream_demuxer_n_pkg;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_RR   = 1'b1;

  localparam int unsigned W_DEFAULT = 8;
  localparam int unsigned S_DEFAULT = 3;

endpackage : stream_demuxer_n_pkg

// File: rtl/stream_demuxer_n_if.sv
// Producer/consumer signal bundle of the 1-to-N stream demultiplexer.
interface stream_demuxer_n_if #(
  parameter int unsigned W = 8,
  parameter int unsigned S = 3
);
  localparam int unsigned N = 32'(1) << S;

  logic             mode;
  logic [W-1:0]     in_data;
  logic [S-1:0]     in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [N*W-1:0]   out_data;
  logic [N-1:0]     out_valid;
  logic [N-1:0]     out_ready;
  logic [S-1:0]     rr_ptr;

  modport master (
    output mode, in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, rr_ptr
  );

  modport slave (
    input  mode, in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, rr_ptr
  );

endinterface : stream_demuxer_n_if

// File: rtl/stream_demuxer_n_demux_chan_buf.sv
// One-entry holding register for a single output channel; a load wins over a
// concurrent drain so a channel can stream one word per cycle without bubbles.
module demux_chan_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         ready,
  output logic [W-1:0] q,
  output logic         valid
);

  logic [W-1:0] data_q;
  logic         valid_q;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      data_q  <= d;
      valid_q <= 1'b1;
    end else if (ready) begin
      valid_q <= 1'b0;
    end
  end

  assign q     = data_q;
  assign valid = valid_q;

endmodule : demux_chan_buf

// File: rtl/stream_demuxer_n.sv
// Registered 1-to-N stream demultiplexer with addressed or round-robin steering
// and an independent one-entry buffer per output channel.
module stream_demuxer_n
  import stream_demuxer_n_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT,
  parameter int unsigned S = S_DEFAULT
) (
  input  logic               clock,
  input  logic               reset_,
  stream_demuxer_n_if.slave  bus
);

  localparam int unsigned N = 32'(1) << S;

  logic [S-1:0] rr_ptr_q;
  logic [S-1:0] rr_ptr_d;
  logic [S-1:0] tgt_c;
  logic         in_ready_c;
  logic         accept_c;
  logic [N-1:0] load_c;
  logic [N-1:0] chan_valid;
  logic [W-1:0] chan_q [N];

  assign tgt_c      = (bus.mode == MODE_RR) ? rr_ptr_q : bus.in_sel;
  assign in_ready_c = ~chan_valid[tgt_c] | bus.out_ready[tgt_c];
  assign accept_c   = bus.in_valid & in_ready_c;

  // One-hot load strobe toward the selected channel
  always_comb begin
    load_c = '0;
    if (accept_c) begin
      load_c[tgt_c] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept_c && (bus.mode == MODE_RR)) begin
      rr_ptr_d = rr_ptr_q + S'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_chan
    demux_chan_buf #(.W(W)) u_buf (
      .clock (clock),
      .reset_(reset_),
      .load  (load_c[k]),
      .d     (bus.in_data),
      .ready (bus.out_ready[k]),
      .q     (chan_q[k]),
      .valid (chan_valid[k])
    );
  end

  always_comb begin
    bus.out_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      bus.out_data[k*W +: W] = chan_q[k];
    end
  end

  assign bus.out_valid = chan_valid;
  assign bus.in_ready  = in_ready_c;
  assign bus.rr_ptr    = rr_ptr_q;

endmodule : stream_demuxer_n

// File: tb/tb_stream_demuxer_n.sv
// Directed self-checking bench for stream_demuxer_n with W=8, S=3.
module tb_stream_demuxer_n;

  logic clock;
  logic reset_;
  int   n_checks;
  int   n_fail;

  stream_demuxer_n_if #(.W(8), .S(3)) bus ();

  stream_demuxer_n #(.W(8), .S(3)) dut (
    .clock (clock),
    .reset_(reset_),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] ch_data(input int k);
    logic [63:0] v;
    v = bus.out_data;
    return v[k*8 +: 8];
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_        = 1'b0;
    bus.mode      = 1'b0;
    bus.in_data   = '0;
    bus.in_sel    = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = '0;
    #12;
    n_checks++;
    if (bus.out_valid !== 8'h00) begin n_fail++; $display("FAIL reset_out_valid: got %b expected %b", bus.out_valid, 8'h00); end
    n_checks++;
    if (bus.out_data !== 64'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data); end
    n_checks++;
    if (bus.rr_ptr !== 3'd0) begin n_fail++; $display("FAIL reset_rr_ptr: got %0d expected 0", bus.rr_ptr); end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    @(negedge clock);
    reset_ = 1'b1;
    step();
  endtask

  task automatic test_addressed();
    bus.mode = 1'b0; bus.out_ready = '0;
    bus.in_data = 8'hA5; bus.in_sel = 3'd5; bus.in_valid = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL addr_first_ready: got %b expected 1", bus.in_ready); end
    step();
    n_checks++;
    if (bus.out_valid !== 8'b0010_0000) begin n_fail++; $display("FAIL addr_out_valid: got %b expected 00100000", bus.out_valid); end
    n_checks++;
    if (ch_data(5) !== 8'hA5) begin n_fail++; $display("FAIL addr_ch5_data: got %h expected a5", ch_data(5)); end
    bus.in_data = 8'h5A;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL addr_full_ready: got %b expected 0", bus.in_ready); end
    step();
    n_checks++;
    if (ch_data(5) !== 8'hA5) begin n_fail++; $display("FAIL addr_held_data: got %h expected a5", ch_data(5)); end
    bus.out_ready[5] = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL addr_drain_ready: got %b expected 1", bus.in_ready); end
    step();
    n_checks++;
    if (ch_data(5) !== 8'h5A || bus.out_valid !== 8'b0010_0000) begin
      n_fail++; $display("FAIL addr_replace: got data %h valid %b expected 5a 00100000", ch_data(5), bus.out_valid);
    end
    bus.in_valid = 1'b0;
    step();
    n_checks++;
    if (bus.out_valid !== 8'h00 || ch_data(5) !== 8'h5A) begin
      n_fail++; $display("FAIL addr_drain: got valid %b data %h expected 00000000 5a", bus.out_valid, ch_data(5));
    end
    bus.out_ready = '0;
  endtask

  task automatic test_drain_load();
    bus.mode = 1'b0; bus.out_ready = '0;
    bus.in_data = 8'h11; bus.in_sel = 3'd2; bus.in_valid = 1'b1;
    step();
    bus.out_ready[2] = 1'b1; bus.in_data = 8'h22;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL dl_ready: got %b expected 1", bus.in_ready); end
    step();
    n_checks++;
    if (bus.out_valid[2] !== 1'b1 || ch_data(2) !== 8'h22) begin
      n_fail++; $display("FAIL dl_replace: got valid %b data %h expected 1 22", bus.out_valid[2], ch_data(2));
    end
    for (int i = 0; i < 8; i++) begin
      bus.in_data = 8'(48 + i);
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL dl_stream_ready[%0d]: got %b expected 1", i, bus.in_ready); end
      step();
      n_checks++;
      if (bus.out_valid !== 8'b0000_0100 || ch_data(2) !== 8'(48 + i)) begin
        n_fail++; $display("FAIL dl_stream_data[%0d]: got valid %b data %h expected 00000100 %h", i, bus.out_valid, ch_data(2), 8'(48 + i));
      end
    end
    bus.in_valid = 1'b0;
    step();
    n_checks++;
    if (bus.out_valid !== 8'h00) begin n_fail++; $display("FAIL dl_final_drain: got %b expected 00000000", bus.out_valid); end
    bus.out_ready = '0;
  endtask

  task automatic test_round_robin();
    bus.mode = 1'b1; bus.out_ready = 8'hFF; bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_data = 8'(i);
      bus.in_sel  = 3'(7 - (i % 8));
      #1;
      n_checks++;
      if (bus.rr_ptr !== 3'(i % 8) || bus.in_ready !== 1'b1) begin
        n_fail++; $display("FAIL rr_ptr_pre[%0d]: got ptr %0d ready %b expected %0d 1", i, bus.rr_ptr, bus.in_ready, i % 8);
      end
      step();
      n_checks++;
      if (bus.out_valid[i % 8] !== 1'b1 || ch_data(i % 8) !== 8'(i)) begin
        n_fail++; $display("FAIL rr_land[%0d]: got ch%0d valid %b data %h expected 1 %h", i, i % 8, bus.out_valid[i % 8], ch_data(i % 8), 8'(i));
      end
    end
    n_checks++;
    if (bus.rr_ptr !== 3'd2) begin n_fail++; $display("FAIL rr_end_ptr: got %0d expected 2", bus.rr_ptr); end
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_rr_stall();
    bus.out_ready = 8'b1111_0111;
    bus.mode = 1'b0; bus.in_sel = 3'd3; bus.in_data = 8'h33; bus.in_valid = 1'b1;
    step();
    bus.mode = 1'b1; bus.in_data = 8'h42;
    step();
    bus.in_data = 8'h44;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.rr_ptr !== 3'd3) begin
        n_fail++; $display("FAIL stall[%0d]: got ready %b ptr %0d expected 0 3", i, bus.in_ready, bus.rr_ptr);
      end
      step();
    end
    n_checks++;
    if (ch_data(3) !== 8'h33) begin n_fail++; $display("FAIL stall_held: got %h expected 33", ch_data(3)); end
    bus.out_ready[3] = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got %b expected 1", bus.in_ready); end
    step();
    n_checks++;
    if (bus.rr_ptr !== 3'd4 || ch_data(3) !== 8'h44) begin
      n_fail++; $display("FAIL stall_release: got ptr %0d data %h expected 4 44", bus.rr_ptr, ch_data(3));
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 8'hFF;
    step();
  endtask

  task automatic test_mode_switch();
    bus.mode = 1'b0; bus.in_sel = 3'd6; bus.in_valid = 1'b1; bus.out_ready = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 8'(96 + i);
      step();
      n_checks++;
      if (bus.rr_ptr !== 3'd4 || ch_data(6) !== 8'(96 + i)) begin
        n_fail++; $display("FAIL ms_addr[%0d]: got ptr %0d data %h expected 4 %h", i, bus.rr_ptr, ch_data(6), 8'(96 + i));
      end
    end
    bus.mode = 1'b1; bus.in_data = 8'h77;
    step();
    n_checks++;
    if (ch_data(4) !== 8'h77 || bus.out_valid[4] !== 1'b1 || bus.rr_ptr !== 3'd5) begin
      n_fail++; $display("FAIL ms_rr: got data %h valid %b ptr %0d expected 77 1 5", ch_data(4), bus.out_valid[4], bus.rr_ptr);
    end
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    logic [7:0] sels [3];
    sels[0] = 3'd0; sels[1] = 3'd3; sels[2] = 3'd7;
    bus.mode = 1'b0; bus.out_ready = '0; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_sel  = 3'(sels[i]);
      bus.in_data = 8'(8'hC0 + sels[i]);
      step();
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 8'b1000_1001) begin n_fail++; $display("FAIL rm_pre_valid: got %b expected 10001001", bus.out_valid); end
    #2;
    reset_ = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 8'h00 || bus.out_data !== 64'h0 || bus.rr_ptr !== 3'd0) begin
      n_fail++; $display("FAIL rm_async: got valid %b data %h ptr %0d expected 0 0 0", bus.out_valid, bus.out_data, bus.rr_ptr);
    end
    @(negedge clock);
    reset_ = 1'b1;
    bus.mode = 1'b1; bus.in_data = 8'h99; bus.in_valid = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready_after: got %b expected 1", bus.in_ready); end
    step();
    n_checks++;
    if (bus.out_valid !== 8'b0000_0001 || ch_data(0) !== 8'h99 || bus.rr_ptr !== 3'd1) begin
      n_fail++; $display("FAIL rm_resume: got valid %b data %h ptr %0d expected 00000001 99 1", bus.out_valid, ch_data(0), bus.rr_ptr);
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_addressed();
    test_drain_load();
    test_round_robin();
    test_rr_stall();
    test_mode_switch();
    test_reset_mid();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_stream_demuxer_n
